// File: rtl/any1_pkg.sv
// Shared types and bus constants for the any1 load/store path.
package any1_pkg;

    localparam int unsigned BUS_DW   = 64;
    localparam int unsigned BUS_SELW = 8;
    localparam int unsigned BUS_AW   = 32;
    localparam int unsigned TAG_W    = 6;

    typedef enum logic [1:0] {
        MS_BYTE  = 2'd0,
        MS_WYDE  = 2'd1,
        MS_TETRA = 2'd2,
        MS_OCTA  = 2'd3
    } MemSize;

    typedef struct packed {
        logic              we;
        MemSize            size;
        logic              sgn;
        logic [BUS_AW-1:0] ea;
        logic [BUS_DW-1:0] data;
        logic [TAG_W-1:0]  tag;
    } MemReq;

    typedef struct packed {
        logic [BUS_DW-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } MemResp;

    // Unshifted byte-lane mask for an access of the given size.
    function automatic logic [BUS_SELW-1:0] size_mask(input MemSize s);
        logic [BUS_SELW-1:0] m;
        unique case (s)
            MS_BYTE:  m = 8'h01;
            MS_WYDE:  m = 8'h03;
            MS_TETRA: m = 8'h0F;
            default:  m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/any1_mem_align.sv
// Byte-lane alignment: lane masks and shifted store data, plus load merge and extension.
module any1_mem_align
    import any1_pkg::*;
(
    input  logic [2:0]            i_off,
    input  MemSize                i_size,
    input  logic                  i_signed,
    input  logic [BUS_DW-1:0]     i_st_data,
    input  logic [BUS_DW-1:0]     i_ld_lo,
    input  logic [BUS_DW-1:0]     i_ld_hi,
    output logic [2*BUS_SELW-1:0] o_mask,
    output logic                  o_split,
    output logic [BUS_DW-1:0]     o_st_lo,
    output logic [BUS_DW-1:0]     o_st_hi,
    output logic [BUS_DW-1:0]     o_ld_data
);

    logic [5:0]          w_shamt;
    logic [2*BUS_DW-1:0] w_st_wide;
    logic [2*BUS_DW-1:0] w_raw;

    assign w_shamt   = {i_off, 3'b000};
    assign o_mask    = {8'h00, size_mask(i_size)} << i_off;
    assign o_split   = |o_mask[15:8];

    // Store data spread over two beats; the upper half is only used when split.
    assign w_st_wide = {64'h0, i_st_data} << w_shamt;
    assign o_st_lo   = w_st_wide[63:0];
    assign o_st_hi   = w_st_wide[127:64];

    assign w_raw     = {i_ld_hi, i_ld_lo} >> w_shamt;

    always_comb begin
        o_ld_data = '0;
        unique case (i_size)
            MS_BYTE:  o_ld_data = {{56{i_signed & w_raw[7]}},  w_raw[7:0]};
            MS_WYDE:  o_ld_data = {{48{i_signed & w_raw[15]}}, w_raw[15:0]};
            MS_TETRA: o_ld_data = {{32{i_signed & w_raw[31]}}, w_raw[31:0]};
            default:  o_ld_data = w_raw[63:0];
        endcase
    end

endmodule

// File: rtl/any1_memstage.sv
// Load/store bus sequencer: one op in flight, one or two bus beats, response with tag.
module any1_memstage
    import any1_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [BUS_AW-1:0]   req_ea,
    input  logic [BUS_DW-1:0]   req_data,
    input  logic [TAG_W-1:0]    req_tag,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [BUS_DW-1:0]   resp_data,
    output logic [TAG_W-1:0]    resp_tag,
    output logic                resp_err,
    output logic                cyc_o,
    output logic                stb_o,
    output logic                we_o,
    output logic [BUS_SELW-1:0] sel_o,
    output logic [BUS_AW-1:0]   adr_o,
    output logic [BUS_DW-1:0]   dat_o,
    input  logic                ack_i,
    input  logic                err_i,
    input  logic [BUS_DW-1:0]   dat_i
);

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StBeat1, StGap, StBeat2, StResp} state_e;

    state_e              r_state, w_state_d;
    MemReq               r_req;
    MemResp              r_resp;
    logic [BUS_DW-1:0]   r_lo;
    logic [7:0]          r_timer;

    logic                w_stb, w_done, w_tmo, w_end, w_bad, w_err_final, w_to_resp;
    logic [2*BUS_SELW-1:0] w_mask;
    logic                w_split;
    logic [BUS_DW-1:0]   w_st_lo, w_st_hi, w_ld_lo, w_ld_hi, w_ld_data;
    logic [BUS_AW-1:0]   w_adr1;

    assign w_stb       = (r_state == StBeat1) || (r_state == StBeat2);
    assign w_done      = w_stb & (ack_i | err_i);
    assign w_tmo       = w_stb & ~(ack_i | err_i) & (r_timer == TMO_LAST);
    assign w_end       = w_done | w_tmo;
    assign w_bad       = (w_stb & err_i) | w_tmo;
    assign w_err_final = r_resp.err | w_bad;
    assign w_to_resp   = (r_state != StResp) && (w_state_d == StResp);
    assign w_adr1      = {r_req.ea[31:3], 3'b000};

    // Second beat merges the stored first-beat word with the live bus data.
    assign w_ld_lo = (r_state == StBeat2) ? r_lo  : dat_i;
    assign w_ld_hi = (r_state == StBeat2) ? dat_i : '0;

    any1_mem_align u_align (
        .i_off     (r_req.ea[2:0]),
        .i_size    (r_req.size),
        .i_signed  (r_req.sgn),
        .i_st_data (r_req.data),
        .i_ld_lo   (w_ld_lo),
        .i_ld_hi   (w_ld_hi),
        .o_mask    (w_mask),
        .o_split   (w_split),
        .o_st_lo   (w_st_lo),
        .o_st_hi   (w_st_hi),
        .o_ld_data (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (req_valid) w_state_d = StBeat1;
            StBeat1: if (w_end) w_state_d = (w_bad || !w_split) ? StResp : StGap;
            StGap:   w_state_d = StBeat2;
            StBeat2: if (w_end) w_state_d = StResp;
            StResp:  if (resp_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req   <= '0;
            r_resp  <= '0;
            r_lo    <= '0;
            r_timer <= '0;
        end else begin
            if (r_state == StIdle && req_valid) begin
                r_req.we   <= req_we;
                r_req.size <= MemSize'(req_size);
                r_req.sgn  <= req_signed;
                r_req.ea   <= req_ea;
                r_req.data <= req_data;
                r_req.tag  <= req_tag;
                r_resp.err <= 1'b0;
            end
            r_timer <= (w_stb && !w_end) ? r_timer + 8'd1 : 8'd0;
            if (r_state == StBeat1 && w_end) begin
                r_lo <= dat_i;
            end
            if (w_end) begin
                r_resp.err <= w_err_final;
            end
            if (w_to_resp) begin
                r_resp.data <= (r_req.we || w_err_final) ? '0 : w_ld_data;
                r_resp.tag  <= r_req.tag;
            end
        end
    end

    always_comb begin
        req_ready  = (r_state == StIdle);
        cyc_o      = w_stb;
        stb_o      = w_stb;
        we_o       = w_stb & r_req.we;
        sel_o      = '0;
        adr_o      = '0;
        dat_o      = '0;
        if (r_state == StBeat1) begin
            sel_o = w_mask[7:0];
            adr_o = w_adr1;
            dat_o = r_req.we ? w_st_lo : '0;
        end else if (r_state == StBeat2) begin
            sel_o = w_mask[15:8];
            adr_o = w_adr1 + 32'd8;
            dat_o = r_req.we ? w_st_hi : '0;
        end
        resp_valid = (r_state == StResp);
        resp_data  = resp_valid ? r_resp.data : '0;
        resp_tag   = resp_valid ? r_resp.tag  : '0;
        resp_err   = resp_valid & r_resp.err;
    end

endmodule

// File: tb/tb_any1_memstage.sv
// Directed bench for any1_memstage with a response scoreboard and bus-beat checks.
module tb_any1_memstage;

    localparam int unsigned TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_ea;
    logic [63:0] req_data;
    logic [5:0]  req_tag;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_data;
    logic [5:0]  resp_tag;
    logic        cyc_o, stb_o, we_o, ack_i, err_i;
    logic [7:0]  sel_o;
    logic [31:0] adr_o;
    logic [63:0] dat_o, dat_i;

    typedef struct {
        logic [63:0] d;
        logic [5:0]  t;
        logic        e;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    any1_memstage #(.TMO_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_ea     (req_ea),
        .req_data   (req_data),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .resp_err   (resp_err),
        .cyc_o      (cyc_o),
        .stb_o      (stb_o),
        .we_o       (we_o),
        .sel_o      (sel_o),
        .adr_o      (adr_o),
        .dat_o      (dat_o),
        .ack_i      (ack_i),
        .err_i      (err_i),
        .dat_i      (dat_i)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL resp_unexpected: got tag %h expected no response", resp_tag);
            end else begin
                e = q.pop_front();
                chk("resp_data", resp_data, e.d);
                chk("resp_tag", {58'h0, resp_tag}, {58'h0, e.t});
                chk("resp_err", {63'h0, resp_err}, {63'h0, e.e});
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] ea, input logic [63:0] data, input logic [5:0] tag,
                         input logic [63:0] exp_d, input logic exp_e, input logic push);
        exp_t e;
        int   n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_ea = ea; req_data = data; req_tag = tag;
        e.d = exp_d; e.t = tag; e.e = exp_e;
        if (push) q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
    endtask

    // Waits for a strobe, checks the beat, then optionally answers with ack or err.
    task automatic beat(input string name, input logic [31:0] adr, input logic [7:0] sel,
                        input logic we, input logic [63:0] wdat, input logic [63:0] rdat,
                        input logic err, input logic respond);
        int n = 0;
        while (!stb_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_stb"}, {63'h0, stb_o & cyc_o}, 64'h1);
        chk({name, "_adr"}, {32'h0, adr_o}, {32'h0, adr});
        chk({name, "_sel"}, {56'h0, sel_o}, {56'h0, sel});
        chk({name, "_we"}, {63'h0, we_o}, {63'h0, we});
        if (we) chk({name, "_dat"}, dat_o, wdat);
        if (respond) begin
            dat_i = rdat;
            ack_i = ~err;
            err_i = err;
            @(posedge clk);
            #1 ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((!req_ready || q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, {63'h0, req_ready && q.size() == 0}, 64'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_ea = '0; req_data = '0; req_tag = '0; resp_ready = 1'b1;
        ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_bus", {61'h0, cyc_o, stb_o, we_o}, 64'h0);
        chk("rst_sel_adr", {24'h0, sel_o, adr_o}, 64'h0);
        chk("rst_dat", dat_o, 64'h0);
        chk("rst_resp", {resp_valid, resp_err, resp_tag, resp_data[55:0]}, 64'h0);

        // Aligned octa store, minimum latency.
        issue(1'b1, 2'd3, 1'b0, 32'h1000, 64'h1122334455667788, 6'd1, 64'h0, 1'b0, 1'b1);
        beat("st8", 32'h1000, 8'hFF, 1'b1, 64'h1122334455667788, 64'h0, 1'b0, 1'b1);
        chk("st8_latency", {63'h0, resp_valid}, 64'h1);
        wait_idle("st8");

        // Split signed tetra load.
        issue(1'b0, 2'd2, 1'b1, 32'h1006, 64'h0, 6'd2, 64'hFFFFFFFFDDCCBBAA, 1'b0, 1'b1);
        beat("ld4_b1", 32'h1000, 8'hC0, 1'b0, 64'h0, 64'hBBAA_0000_0000_0000, 1'b0, 1'b1);
        chk("ld4_gap", {63'h0, cyc_o}, 64'h0);
        beat("ld4_b2", 32'h1008, 8'h03, 1'b0, 64'h0, 64'h0000_0000_0000_DDCC, 1'b0, 1'b1);
        wait_idle("ld4");

        // Byte load, signed then unsigned.
        issue(1'b0, 2'd0, 1'b1, 32'h2003, 64'h0, 6'd3, 64'hFFFFFFFFFFFFFF80, 1'b0, 1'b1);
        beat("ldb_s", 32'h2000, 8'h08, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 1'b1);
        wait_idle("ldb_s");
        issue(1'b0, 2'd0, 1'b0, 32'h2003, 64'h0, 6'd4, 64'h80, 1'b0, 1'b1);
        beat("ldb_u", 32'h2000, 8'h08, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 1'b1);
        wait_idle("ldb_u");

        // Unaligned wyde store inside one doubleword.
        issue(1'b1, 2'd1, 1'b0, 32'h3001, 64'hA55A, 6'd7, 64'h0, 1'b0, 1'b1);
        beat("stw", 32'h3000, 8'h06, 1'b1, 64'h0000_0000_00A5_5A00, 64'h0, 1'b0, 1'b1);
        wait_idle("stw");

        // Split load wrapping the top of the address space.
        issue(1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 64'h0, 6'd8, 64'h1234, 1'b0, 1'b1);
        beat("wrap_b1", 32'hFFFF_FFF8, 8'h80, 1'b0, 64'h0, 64'h3400_0000_0000_0000, 1'b0, 1'b1);
        beat("wrap_b2", 32'h0000_0000, 8'h01, 1'b0, 64'h0, 64'h0000_0000_0000_0012, 1'b0, 1'b1);
        wait_idle("wrap");

        // Split store with error on the first beat: second beat is skipped.
        issue(1'b1, 2'd2, 1'b0, 32'h0FFE, 64'hCAFEBABE, 6'd5, 64'h0, 1'b1, 1'b1);
        beat("sterr", 32'h0FF8, 8'hC0, 1'b1, 64'hBABE_0000_0000_0000, 64'h0, 1'b1, 1'b1);
        chk("sterr_no_beat2", {62'h0, stb_o, resp_valid}, 64'h1);
        wait_idle("sterr");

        // Timeout with the consumer stalled.
        resp_ready = 1'b0;
        issue(1'b0, 2'd3, 1'b0, 32'h4000, 64'h0, 6'd6, 64'h0, 1'b1, 1'b1);
        n = 0;
        while (stb_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_cycles", 64'(n), 64'(TMO));
        for (int i = 0; i < 5; i++) begin
            chk("tmo_hold", {resp_valid, resp_err, resp_tag, cyc_o, resp_data[54:0]},
                {1'b1, 1'b1, 6'd6, 1'b0, 55'h0});
            @(negedge clk);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_idle("tmo");

        // Reset while the second beat is on the bus: no response may follow.
        issue(1'b0, 2'd1, 1'b0, 32'h5007, 64'h0, 6'd9, 64'h0, 1'b0, 1'b0);
        beat("rst_b1", 32'h5000, 8'h80, 1'b0, 64'h0, 64'hFF00_0000_0000_0000, 1'b0, 1'b1);
        beat("rst_b2", 32'h5008, 8'h01, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid", {61'h0, cyc_o, resp_valid, req_ready}, 64'h1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_mid_quiet", {62'h0, resp_valid, stb_o}, 64'h0);
        chk("queue_empty", 64'(q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
